// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32 instruction-decode stage.
// Decodes op/func3/func7 into the control bundle for EX and holds it in a
// single-entry output register with a valid/ready handshake. It adds
// pipeline flush, illegal-instruction flagging and an optional
// M-extension occupancy counter.
// Optional feature macro: DECODE_CTRL_M_EXT_EN (enables the M-extension path).
//
// Control encodings:
//   imm_src     : 000 I, 001 S, 010 B, 011 J, 100 U
//   result_src  : 000 ALU, 001 memory, 010 PC+4, 011 immediate, 100 PC+imm
//   alu_control : 00000 add, 00001 sub, 00010 sll, 00011 slt, 00100 sltu,
//                 00101 xor, 00110 srl, 00111 sra, 01000 or, 01001 and
//   forward_src : 00 ALU, 01 PC+4, 10 immediate, 11 PC+imm
module decode_ctrl_stage #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32
) (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic [31:0] i_instr,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_flush,
  output logic [2:0]  o_imm_src,
  output logic [2:0]  o_result_src,
  output logic [4:0]  o_alu_control,
  output logic        o_mem_we,
  output logic        o_reg_we,
  output logic        o_alu_src,
  output logic        o_branch,
  output logic        o_jump,
  output logic [1:0]  o_forward_src,
  output logic        o_load_instr,
  output logic        o_illegal,
  output logic        o_muldiv,
  output logic [2:0]  o_muldiv_op,
  output logic        o_busy
);

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_AND  = 5'b01001;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t      state;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic        func7_5;
  logic        is_m;
  logic        accept;
  logic        handoff;
  logic        load;
  logic        next_valid;
  logic        busy_now;

  logic [2:0]  dec_imm_src;
  logic [2:0]  dec_result_src;
  logic [4:0]  dec_alu_control;
  logic        dec_mem_we;
  logic        dec_reg_we;
  logic        dec_alu_src;
  logic        dec_branch;
  logic        dec_jump;
  logic [1:0]  dec_forward_src;
  logic        dec_load_instr;
  logic        dec_supported;
  logic        dec_illegal;
  logic        dec_muldiv;
  logic [2:0]  dec_muldiv_op;

  assign op      = i_instr[6:0];
  assign func3   = i_instr[14:12];
  assign func7_5 = i_instr[30];
  assign is_m    = (op == 7'b0110011) && (i_instr[31:25] == 7'b0000001);

  // ALU operation for register/immediate arithmetic; arith selects sub/sra.
  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic arith);
    case (f3)
      3'b000:  alu_op = arith ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = arith ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // Main/ALU decode of the incoming instruction, then illegal and M overrides.
  always_comb begin
    dec_imm_src     = 3'b000;
    dec_result_src  = 3'b000;
    dec_alu_control = ALU_ADD;
    dec_mem_we      = 1'b0;
    dec_reg_we      = 1'b0;
    dec_alu_src     = 1'b0;
    dec_branch      = 1'b0;
    dec_jump        = 1'b0;
    dec_forward_src = 2'b00;
    dec_load_instr  = 1'b0;
    dec_supported   = 1'b1;
    dec_illegal     = 1'b0;
    dec_muldiv      = 1'b0;
    dec_muldiv_op   = 3'b000;
    case (op)
      7'b0110011: begin
        dec_reg_we      = 1'b1;
        dec_alu_control = alu_op(func3, func7_5);
      end
      7'b0010011: begin
        dec_reg_we      = 1'b1;
        dec_alu_src     = 1'b1;
        dec_alu_control = alu_op(func3, (func3 == 3'b101) && func7_5);
      end
      7'b0000011: begin
        dec_reg_we     = 1'b1;
        dec_alu_src    = 1'b1;
        dec_result_src = 3'b001;
        dec_load_instr = 1'b1;
      end
      7'b0100011: begin
        dec_imm_src = 3'b001;
        dec_alu_src = 1'b1;
        dec_mem_we  = 1'b1;
      end
      7'b1100011: begin
        dec_imm_src = 3'b010;
        dec_branch  = 1'b1;
        case (func3)
          3'b100, 3'b101: dec_alu_control = ALU_SLT;
          3'b110, 3'b111: dec_alu_control = ALU_SLTU;
          default:        dec_alu_control = ALU_SUB;
        endcase
      end
      7'b1101111: begin
        dec_imm_src     = 3'b011;
        dec_jump        = 1'b1;
        dec_reg_we      = 1'b1;
        dec_result_src  = 3'b010;
        dec_forward_src = 2'b01;
      end
      7'b1100111: begin
        dec_jump        = 1'b1;
        dec_reg_we      = 1'b1;
        dec_alu_src     = 1'b1;
        dec_result_src  = 3'b010;
        dec_forward_src = 2'b01;
      end
      7'b0110111: begin
        dec_imm_src     = 3'b100;
        dec_reg_we      = 1'b1;
        dec_result_src  = 3'b011;
        dec_forward_src = 2'b10;
      end
      7'b0010111: begin
        dec_imm_src     = 3'b100;
        dec_reg_we      = 1'b1;
        dec_result_src  = 3'b100;
        dec_forward_src = 2'b11;
      end
      default: dec_supported = 1'b0;
    endcase
`ifdef DECODE_CTRL_M_EXT_EN
    if (is_m) begin
      dec_muldiv     = 1'b1;
      dec_muldiv_op  = func3;
      dec_reg_we     = 1'b1;
      dec_result_src = 3'b000;
    end
    dec_illegal = !dec_supported;
`else
    dec_illegal = !dec_supported || is_m;
`endif
    if (dec_illegal) begin
      dec_reg_we = 1'b0;
      dec_mem_we = 1'b0;
      dec_branch = 1'b0;
      dec_jump   = 1'b0;
    end
  end

`ifdef DECODE_CTRL_M_EXT_EN
  logic [7:0] cnt;
  logic [7:0] next_cnt;
  logic       unused_bits;

  assign busy_now    = (cnt != 8'd0);
  assign unused_bits = ^{i_instr[24:15], i_instr[11:7], dec_muldiv_op};

  // Occupancy countdown: flush clears, an M handoff loads its latency.
  always_comb begin
    next_cnt = busy_now ? cnt - 8'd1 : cnt;
    if (i_flush) begin
      next_cnt = 8'd0;
    end else if (handoff && o_muldiv) begin
      next_cnt = o_muldiv_op[2] ? 8'(DIV_LATENCY) : 8'(MUL_LATENCY);
    end
  end

  // Occupancy counter register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cnt <= 8'd0;
    end else begin
      cnt <= next_cnt;
    end
  end
`else
  logic unused_bits;

  assign busy_now    = 1'b0;
  assign o_muldiv    = 1'b0;
  assign o_muldiv_op = 3'b000;
  assign unused_bits = ^{i_instr[24:15], i_instr[11:7], dec_muldiv, dec_muldiv_op,
                         8'(MUL_LATENCY), 8'(DIV_LATENCY)};
`endif

  assign o_busy  = busy_now;
  assign o_ready = !i_flush && !busy_now && ((state != HELD) || i_ready);
  assign accept  = i_valid && o_ready;
  assign handoff = o_valid && i_ready;

  // Stage state derived from the valid flag and occupancy.
  always_comb begin
    state = EMPTY;
    if (o_valid) begin
      state = HELD;
    end else if (busy_now) begin
      state = BUSY;
    end
  end

  // Next valid flag and bundle load: flush wins, then accept, then handoff.
  always_comb begin
    next_valid = o_valid;
    load       = 1'b0;
    if (i_flush) begin
      next_valid = 1'b0;
    end else if (accept) begin
      next_valid = 1'b1;
      load       = 1'b1;
    end else if (handoff) begin
      next_valid = 1'b0;
    end
  end

  // Valid flag register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= next_valid;
    end
  end

  // Control bundle register; loads only on accept so a stalled bundle holds.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_imm_src     <= 3'b000;
      o_result_src  <= 3'b000;
      o_alu_control <= 5'b00000;
      o_mem_we      <= 1'b0;
      o_reg_we      <= 1'b0;
      o_alu_src     <= 1'b0;
      o_branch      <= 1'b0;
      o_jump        <= 1'b0;
      o_forward_src <= 2'b00;
      o_load_instr  <= 1'b0;
      o_illegal     <= 1'b0;
`ifdef DECODE_CTRL_M_EXT_EN
      o_muldiv      <= 1'b0;
      o_muldiv_op   <= 3'b000;
`endif
    end else if (load) begin
      o_imm_src     <= dec_imm_src;
      o_result_src  <= dec_result_src;
      o_alu_control <= dec_alu_control;
      o_mem_we      <= dec_mem_we;
      o_reg_we      <= dec_reg_we;
      o_alu_src     <= dec_alu_src;
      o_branch      <= dec_branch;
      o_jump        <= dec_jump;
      o_forward_src <= dec_forward_src;
      o_load_instr  <= dec_load_instr;
      o_illegal     <= dec_illegal;
`ifdef DECODE_CTRL_M_EXT_EN
      o_muldiv      <= dec_muldiv;
      o_muldiv_op   <= dec_muldiv_op;
`endif
    end
  end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed self-checking bench for decode_ctrl_stage.
// Exercises both builds; M-extension steps depend on DECODE_CTRL_M_EXT_EN.
module tb_decode_ctrl_stage;

  localparam logic [31:0] INSTR_ADD  = 32'h003100B3;
  localparam logic [31:0] INSTR_SUB  = 32'h403100B3;
  localparam logic [31:0] INSTR_LW   = 32'h0000A083;
  localparam logic [31:0] INSTR_BAD  = 32'h0000007F;
  localparam logic [31:0] INSTR_SW   = 32'h0020A023;
  localparam logic [31:0] INSTR_BEQ  = 32'h00208063;
  localparam logic [31:0] INSTR_JAL  = 32'h008000EF;
  localparam logic [31:0] INSTR_LUI  = 32'h123450B7;
  localparam logic [31:0] INSTR_DIV  = 32'h023140B3;
  localparam logic [31:0] INSTR_MUL  = 32'h023100B3;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        inValid;
  logic        outReady;
  logic        outValid;
  logic        exReady;
  logic        flush;
  logic [2:0]  immSrc;
  logic [2:0]  resultSrc;
  logic [4:0]  aluControl;
  logic        memWe;
  logic        regWe;
  logic        aluSrc;
  logic        branch;
  logic        jump;
  logic [1:0]  forwardSrc;
  logic        loadInstr;
  logic        illegal;
  logic        mulDiv;
  logic [2:0]  mulDivOp;
  logic        busy;

  int compared;
  int mismatched;

  decode_ctrl_stage dut (
    .i_clk         (clk),
    .i_arst        (rst),
    .i_instr       (instr),
    .i_valid       (inValid),
    .o_ready       (outReady),
    .o_valid       (outValid),
    .i_ready       (exReady),
    .i_flush       (flush),
    .o_imm_src     (immSrc),
    .o_result_src  (resultSrc),
    .o_alu_control (aluControl),
    .o_mem_we      (memWe),
    .o_reg_we      (regWe),
    .o_alu_src     (aluSrc),
    .o_branch      (branch),
    .o_jump        (jump),
    .o_forward_src (forwardSrc),
    .o_load_instr  (loadInstr),
    .o_illegal     (illegal),
    .o_muldiv      (mulDiv),
    .o_muldiv_op   (mulDivOp),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] newInstr, input logic newValid,
                               input logic newReady, input logic newFlush);
    instr   = newInstr;
    inValid = newValid;
    exReady = newReady;
    flush   = newFlush;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

`ifdef DECODE_CTRL_M_EXT_EN
  // Counts cycles with o_busy high after an M handoff; bounded.
  task automatic countBusy(input string tag, input int expected);
    int n;
    logic readySeen;
    logic validSeen;
    n = 0;
    readySeen = 1'b0;
    validSeen = 1'b0;
    while (busy && n < 100) begin
      if (outReady) readySeen = 1'b1;
      if (outValid) validSeen = 1'b1;
      n++;
      tick();
    end
    checkOutput({tag, "_busy_cycles"}, n, expected);
    checkOutput({tag, "_ready_while_busy"}, readySeen, 0);
    checkOutput({tag, "_valid_while_busy"}, validSeen, 0);
    checkOutput({tag, "_ready_after"}, outReady, 1);
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_regwe", regWe, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_muldiv", {mulDiv, mulDivOp}, 0);
    checkOutput("rst_ready", outReady, 1);
    rst = 1'b0;
    tick();

    $display("[TB] add and back-to-back sub");
    applyStimulus(INSTR_ADD, 1'b1, 1'b1, 1'b0);
    checkOutput("add_ready_in", outReady, 1);
    tick();
    checkOutput("add_valid", outValid, 1);
    checkOutput("add_regwe", regWe, 1);
    checkOutput("add_memwe", memWe, 0);
    checkOutput("add_illegal", illegal, 0);
    checkOutput("add_alu", aluControl, 5'b00000);
    checkOutput("add_ready_b2b", outReady, 1);
    applyStimulus(INSTR_SUB, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("sub_valid", outValid, 1);
    checkOutput("sub_alu", aluControl, 5'b00001);

    $display("[TB] lw with EX stalled");
    applyStimulus(INSTR_LW, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(INSTR_BAD, 1'b1, 1'b0, 1'b0);
    checkOutput("lw_ready_stall", outReady, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("lw_valid", outValid, 1);
      checkOutput("lw_load", loadInstr, 1);
      checkOutput("lw_bundle", {resultSrc, aluSrc, regWe, immSrc, aluControl},
                  {3'b001, 1'b1, 1'b1, 3'b000, 5'b00000});
      checkOutput("lw_ready_hold", outReady, 0);
      tick();
    end
    applyStimulus(INSTR_BAD, 1'b1, 1'b1, 1'b0);
    checkOutput("lw_ready_handoff", outReady, 1);
    tick();

    $display("[TB] illegal opcode");
    checkOutput("bad_valid", outValid, 1);
    checkOutput("bad_illegal", illegal, 1);
    checkOutput("bad_writes", {regWe, memWe, branch, jump}, 0);
    checkOutput("bad_load", loadInstr, 0);

    $display("[TB] store, branch, jal, lui");
    applyStimulus(INSTR_SW, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("sw_ctrl", {memWe, regWe, immSrc, aluSrc, illegal},
                {1'b1, 1'b0, 3'b001, 1'b1, 1'b0});
    applyStimulus(INSTR_BEQ, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("beq_ctrl", {branch, jump, regWe, immSrc, aluControl},
                {1'b1, 1'b0, 1'b0, 3'b010, 5'b00001});
    applyStimulus(INSTR_JAL, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("jal_ctrl", {jump, regWe, immSrc, resultSrc, forwardSrc},
                {1'b1, 1'b1, 3'b011, 3'b010, 2'b01});
    applyStimulus(INSTR_LUI, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("lui_ctrl", {regWe, immSrc, resultSrc, forwardSrc},
                {1'b1, 3'b100, 3'b011, 2'b10});

`ifdef DECODE_CTRL_M_EXT_EN
    $display("[TB] div occupancy");
    applyStimulus(INSTR_DIV, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("div_muldiv", {mulDiv, mulDivOp}, {1'b1, 3'b100});
    checkOutput("div_ctrl", {regWe, resultSrc, illegal}, {1'b1, 3'b000, 1'b0});
    applyStimulus(INSTR_MUL, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("div_busy_start", busy, 1);
    applyStimulus(INSTR_MUL, 1'b1, 1'b0, 1'b0);
    countBusy("div", 32);
    tick();
    $display("[TB] mul occupancy");
    checkOutput("mul_accepted", outValid, 1);
    checkOutput("mul_muldiv", {mulDiv, mulDivOp}, {1'b1, 3'b000});
    applyStimulus(INSTR_ADD, 1'b0, 1'b1, 1'b0);
    tick();
    countBusy("mul", 2);

    $display("[TB] flush during busy");
    applyStimulus(INSTR_DIV, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(INSTR_ADD, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 22; i++) tick();
    checkOutput("flush_busy_before", busy, 1);
    applyStimulus(INSTR_ADD, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_ready", outReady, 0);
    tick();
    applyStimulus(INSTR_ADD, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_busy_after", busy, 0);
    checkOutput("flush_valid_after", outValid, 0);
    checkOutput("flush_ready_after", outReady, 1);

    $display("[TB] reset during busy");
    applyStimulus(INSTR_DIV, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(INSTR_ADD, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("rstbusy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstbusy_busy", busy, 0);
    checkOutput("rstbusy_muldiv", {mulDiv, mulDivOp, regWe}, 0);
    rst = 1'b0;
    #1;
    checkOutput("rstbusy_ready", outReady, 1);
    tick();
`else
    $display("[TB] div without M extension");
    applyStimulus(INSTR_DIV, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("div_illegal", illegal, 1);
    checkOutput("div_writes", {regWe, memWe, branch, jump}, 0);
    checkOutput("div_muldiv", {mulDiv, mulDivOp}, 0);
    applyStimulus(INSTR_ADD, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("div_busy", busy, 0);
    checkOutput("div_valid_after", outValid, 0);
    checkOutput("div_ready_after", outReady, 1);
`endif

    $display("[TB] flush while held");
    applyStimulus(INSTR_ADD, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("fheld_valid", outValid, 1);
    applyStimulus(INSTR_SW, 1'b1, 1'b0, 1'b1);
    checkOutput("fheld_ready", outReady, 0);
    tick();
    applyStimulus(INSTR_SW, 1'b0, 1'b0, 1'b0);
    checkOutput("fheld_valid_after", outValid, 0);
    tick();
    checkOutput("fheld_valid_later", outValid, 0);

    $display("[TB] reset while held");
    applyStimulus(INSTR_LW, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(INSTR_LW, 1'b0, 1'b0, 1'b0);
    checkOutput("rheld_load", loadInstr, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rheld_valid", outValid, 0);
    checkOutput("rheld_bundle", {loadInstr, regWe, aluSrc, resultSrc}, 0);
    rst = 1'b0;
    #1;
    checkOutput("rheld_ready", outReady, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
